// File: rtl/sd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_sched_pkg
// Description : Shared definitions for the SD sector scheduler. It holds the
//               arbiter state encoding, the bus-owner codes, the default
//               parameter values and a saturating increment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } sd_state_e;

  localparam logic OWN_META = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int DEF_UPDATE_EVERY   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;
  localparam int WDOG_W             = 24;
  localparam int DCNT_W             = 8;

  // Saturating +1 for the data-sector counter.
  function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
    return (v == {DCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_watchdog_counter.sv
`default_nettype none
// ============================================================================
// Module      : sd_watchdog_counter
// Description : Per-transaction cycle budget counter for the host interface.
// Ports       : clk, rstn      - clock, asynchronous active-low reset
//               clear          - zero the count (issue cycle of a transaction)
//               enable         - count this cycle (host wait states)
//               limit[W-1:0]   - transaction budget in cycles
//               expired        - budget used up in the current cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sd_watchdog_counter
  import sd_sched_pkg::*;
#(
  parameter int W = WDOG_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W:0] TWO = (W+1)'(2);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the wait cycles already completed. The issue cycle and the
  // current cycle also belong to the transaction, hence the +2: expiry is
  // flagged in the limit-th cycle of the transaction, so the registered error
  // lands exactly 'limit' cycles after the issue cycle.
  assign expired = enable && !clear && (({1'b0, count_q} + TWO) >= {1'b0, limit});

endmodule
`default_nettype wire

// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sd_sector_arbiter
// Description : Arbitrates a single SD host command port between a metadata
//               requester and a data-stream requester. Forces a filesystem
//               metadata update after UPDATE_EVERY data sectors and guards
//               every host transaction with a watchdog.
// Ports       : clk, rstn                 - clock, asynchronous active-low reset
//               card_ready                - card reached transfer-ready
//               m_req/m_wr/m_sector       - metadata request, direction, sector
//               m_grant/m_done/m_err      - metadata grant, done and error
//               d_req/d_sector            - data write request, sector
//               d_grant/d_done/d_err      - data grant, done and error
//               h_start/h_wr/h_sector     - host command start, direction, sector
//               h_busy/h_done             - host busy level, completion pulse
//               sel                       - bus owner (0 metadata, 1 data)
//               update_due/timeout_err    - forced-update flag, sticky timeout
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_arbiter
  import sd_sched_pkg::*;
#(
  parameter int UPDATE_EVERY   = DEF_UPDATE_EVERY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        card_ready,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [31:0] m_sector,
  output logic        m_grant,
  output logic        m_done,
  output logic        m_err,
  input  logic        d_req,
  input  logic [31:0] d_sector,
  output logic        d_grant,
  output logic        d_done,
  output logic        d_err,
  output logic        h_start,
  output logic        h_wr,
  output logic [31:0] h_sector,
  input  logic        h_busy,
  input  logic        h_done,
  output logic        sel,
  output logic        update_due,
  output logic        timeout_err
);

  localparam logic [WDOG_W-1:0] TO_LIMIT  = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic [DCNT_W-1:0] UPD_LIMIT = DCNT_W'(UPDATE_EVERY);

  sd_state_e state_q, state_d;

  // Registered copies of the requester inputs; arbitration looks only at these.
  logic        m_req_s_q, m_req_s_d;
  logic        m_wr_s_q, m_wr_s_d;
  logic [31:0] m_sector_s_q, m_sector_s_d;
  logic        d_req_s_q, d_req_s_d;
  logic [31:0] d_sector_s_q, d_sector_s_d;

  // Transaction latches, held from ISSUE through FINISH and beyond while idle.
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [31:0] sector_q, sector_d;

  logic              prio_q, prio_d;   // owner favoured on the next contention
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              upd_q, upd_d;
  logic              m_err_q, m_err_d;
  logic              d_err_q, d_err_d;
  logic              tout_q, tout_d;

  logic elig_m, elig_d, win, raise_err;
  logic wd_clear, wd_enable, wd_expired;

  sd_watchdog_counter #(
    .W (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (TO_LIMIT),
    .expired (wd_expired)
  );

  // While an update is due the data stream is held off entirely, even if the
  // metadata side is not asking yet.
  assign elig_m = m_req_s_q;
  assign elig_d = d_req_s_q && !upd_q;
  assign win    = (elig_m && elig_d) ? prio_q : (elig_m ? OWN_META : OWN_DATA);

  always_comb begin
    state_d      = state_q;
    m_req_s_d    = m_req;
    m_wr_s_d     = m_wr;
    m_sector_s_d = m_sector;
    d_req_s_d    = d_req;
    d_sector_s_d = d_sector;
    owner_d      = owner_q;
    wr_d         = wr_q;
    sector_d     = sector_q;
    prio_d       = prio_q;
    tout_d       = tout_q;
    raise_err    = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (card_ready && (elig_m || elig_d)) begin
          owner_d  = win;
          wr_d     = (win == OWN_DATA) ? 1'b1 : m_wr_s_q;
          sector_d = (win == OWN_DATA) ? d_sector_s_q : m_sector_s_q;
          if (elig_m && elig_d) begin
            prio_d = ~win;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_clear = 1'b1;
        if (!card_ready) begin
          raise_err = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        wd_enable = 1'b1;
        // Losing the card aborts everything; a completion beats a watchdog
        // expiry arriving in the same cycle.
        if (!card_ready) begin
          raise_err = 1'b1;
          state_d   = ST_IDLE;
        end else if (h_done) begin
          state_d = ST_FINISH;
        end else if (wd_expired) begin
          raise_err = 1'b1;
          tout_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if ((state_q == ST_WAIT_BUSY) && h_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    m_err_d = raise_err && (owner_q == OWN_META);
    d_err_d = raise_err && (owner_q == OWN_DATA);

    // Only completed transactions move the counter; errors leave it alone.
    dcnt_d = dcnt_q;
    if (d_done) begin
      dcnt_d = sat_inc(dcnt_q);
    end else if (m_done && wr_q) begin
      dcnt_d = '0;
    end
    upd_d = (dcnt_d >= UPD_LIMIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      m_req_s_q    <= 1'b0;
      m_wr_s_q     <= 1'b0;
      m_sector_s_q <= '0;
      d_req_s_q    <= 1'b0;
      d_sector_s_q <= '0;
      owner_q      <= OWN_META;
      wr_q         <= 1'b0;
      sector_q     <= '0;
      prio_q       <= OWN_META;
      dcnt_q       <= '0;
      upd_q        <= 1'b0;
      m_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_s_q    <= m_req_s_d;
      m_wr_s_q     <= m_wr_s_d;
      m_sector_s_q <= m_sector_s_d;
      d_req_s_q    <= d_req_s_d;
      d_sector_s_q <= d_sector_s_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      sector_q     <= sector_d;
      prio_q       <= prio_d;
      dcnt_q       <= dcnt_d;
      upd_q        <= upd_d;
      m_err_q      <= m_err_d;
      d_err_q      <= d_err_d;
      tout_q       <= tout_d;
    end
  end

  assign m_grant     = (state_q != ST_IDLE) && (owner_q == OWN_META);
  assign d_grant     = (state_q != ST_IDLE) && (owner_q == OWN_DATA);
  assign m_done      = (state_q == ST_FINISH) && (owner_q == OWN_META);
  assign d_done      = (state_q == ST_FINISH) && (owner_q == OWN_DATA);
  assign m_err       = m_err_q;
  assign d_err       = d_err_q;
  assign h_start     = (state_q == ST_ISSUE);
  assign h_wr        = wr_q;
  assign h_sector    = sector_q;
  assign sel         = owner_q;
  assign update_due  = upd_q;
  assign timeout_err = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_sector_arbiter
// Description : Directed self-checking bench for sd_sector_arbiter
//               (UPDATE_EVERY=4, TIMEOUT_CYCLES=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sector_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        card_ready = 1'b0;
  logic        m_req = 1'b0, m_wr = 1'b0;
  logic [31:0] m_sector = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_sector = '0;
  logic        m_grant, m_done, m_err, d_grant, d_done, d_err;
  logic        h_start, h_wr, sel, update_due, timeout_err;
  logic [31:0] h_sector;
  logic        h_busy, h_done;
  logic        tb_busy = 1'b0, tb_done = 1'b0;
  logic        auto_busy = 1'b0, auto_done = 1'b0, host_auto = 1'b0;

  assign h_busy = tb_busy | auto_busy;
  assign h_done = tb_done | auto_done;

  int checks = 0;
  int failures = 0;
  int n_mdone = 0, n_ddone = 0, n_merr = 0, n_derr = 0, n_start = 0;
  logic        st_sel[$];
  logic        st_wr[$];
  logic        st_gok[$];
  logic [31:0] st_sec[$];

  sd_sector_arbiter #(
    .UPDATE_EVERY   (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk(clk), .rstn(rstn), .card_ready(card_ready),
    .m_req(m_req), .m_wr(m_wr), .m_sector(m_sector),
    .m_grant(m_grant), .m_done(m_done), .m_err(m_err),
    .d_req(d_req), .d_sector(d_sector),
    .d_grant(d_grant), .d_done(d_done), .d_err(d_err),
    .h_start(h_start), .h_wr(h_wr), .h_sector(h_sector),
    .h_busy(h_busy), .h_done(h_done),
    .sel(sel), .update_due(update_due), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Pulse counters and per-command log, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_done === 1'b1) n_mdone++;
    if (d_done === 1'b1) n_ddone++;
    if (m_err === 1'b1) n_merr++;
    if (d_err === 1'b1) n_derr++;
    if (h_start === 1'b1) begin
      n_start++;
      st_sel.push_back(sel);
      st_wr.push_back(h_wr);
      st_sec.push_back(h_sector);
      st_gok.push_back(sel ? (d_grant && !m_grant) : (m_grant && !d_grant));
    end
  end

  // Simple host: busy one cycle after start, done the cycle after.
  initial begin
    forever begin
      @(negedge clk);
      if (host_auto && h_start === 1'b1) begin
        @(posedge clk); #1 auto_busy = 1'b1;
        @(posedge clk); #1 auto_busy = 1'b0; auto_done = 1'b1;
        @(posedge clk); #1 auto_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step_n(3);
    checks++; if ({m_grant, d_grant, h_start, h_wr, sel} !== 5'b0) begin failures++;
      $display("FAIL reset_ctrl: got=%b required=00000", {m_grant, d_grant, h_start, h_wr, sel}); end
    checks++; if (h_sector !== 32'h0) begin failures++;
      $display("FAIL reset_sector: got=%h required=0", h_sector); end
    checks++; if ({m_done, d_done, m_err, d_err} !== 4'b0) begin failures++;
      $display("FAIL reset_pulses: got=%b required=0000", {m_done, d_done, m_err, d_err}); end
    checks++; if ({update_due, timeout_err} !== 2'b0) begin failures++;
      $display("FAIL reset_flags: got=%b required=00", {update_due, timeout_err}); end
    rstn = 1'b1;
    card_ready = 1'b1;
    step_n(2);
  endtask

  task automatic test_meta_read();
    int b_md, b_st, b_dd;
    b_md = n_mdone; b_st = n_start; b_dd = n_ddone;
    m_req = 1'b1; m_wr = 1'b0; m_sector = 32'h0000_0000;
    step();
    checks++; if ({h_start, m_grant} !== 2'b00) begin failures++;
      $display("FAIL mr_cycle1: got=%b required=00", {h_start, m_grant}); end
    step();
    checks++; if ({h_start, m_grant, d_grant, h_wr, sel} !== 5'b11000) begin failures++;
      $display("FAIL mr_issue: got=%b required=11000", {h_start, m_grant, d_grant, h_wr, sel}); end
    m_req = 1'b0;
    tb_busy = 1'b1;
    step_n(3);
    tb_busy = 1'b0; tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    checks++; if ({m_done, m_grant} !== 2'b11) begin failures++;
      $display("FAIL mr_finish: got=%b required=11", {m_done, m_grant}); end
    step();
    checks++; if ({m_done, m_grant} !== 2'b00) begin failures++;
      $display("FAIL mr_release: got=%b required=00", {m_done, m_grant}); end
    step_n(4);
    checks++; if ((n_mdone - b_md) !== 1 || (n_start - b_st) !== 1 || (n_ddone - b_dd) !== 0) begin failures++;
      $display("FAIL mr_counts: got=done%0d/start%0d/ddone%0d required=1/1/0",
               n_mdone - b_md, n_start - b_st, n_ddone - b_dd); end
    checks++; if (update_due !== 1'b0) begin failures++;
      $display("FAIL mr_update_due: got=%b required=0", update_due); end
  endtask

  task automatic test_alternate();
    int q0, b_md, b_dd;
    logic exp_sel;
    q0 = st_sel.size(); b_md = n_mdone; b_dd = n_ddone;
    host_auto = 1'b1;
    m_wr = 1'b1; m_sector = 32'hA5A5_0001; d_sector = 32'h0000_1234;
    m_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 300 && st_sel.size() < q0 + 4; i++) step();
    m_req = 1'b0; d_req = 1'b0;
    checks++; if (st_sel.size() < q0 + 4) begin failures++;
      $display("FAIL alt_starts: got=%0d required=4", st_sel.size() - q0); end
    if (st_sel.size() >= q0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_sel = k[0];
        checks++; if (st_sel[q0+k] !== exp_sel || st_gok[q0+k] !== 1'b1 || st_wr[q0+k] !== 1'b1) begin failures++;
          $display("FAIL alt_owner%0d: got=sel%b/gok%b/wr%b required=sel%b/gok1/wr1",
                   k, st_sel[q0+k], st_gok[q0+k], st_wr[q0+k], exp_sel); end
        checks++; if (st_sec[q0+k] !== (exp_sel ? 32'h0000_1234 : 32'hA5A5_0001)) begin failures++;
          $display("FAIL alt_sector%0d: got=%h", k, st_sec[q0+k]); end
      end
    end
    for (int i = 0; i < 50 && (m_grant || d_grant); i++) step();
    step_n(3);
    checks++; if ((n_mdone - b_md) !== 2 || (n_ddone - b_dd) !== 2) begin failures++;
      $display("FAIL alt_done: got=m%0d/d%0d required=m2/d2", n_mdone - b_md, n_ddone - b_dd); end
  endtask

  // Counter is 1 on entry (last of the alternation was a data write).
  task automatic test_update_due();
    int b_dd, b_st;
    b_dd = n_ddone;
    d_sector = 32'h0000_2000;
    d_req = 1'b1;
    for (int i = 0; i < 300 && update_due !== 1'b1; i++) step();
    checks++; if (update_due !== 1'b1 || (n_ddone - b_dd) !== 3) begin failures++;
      $display("FAIL ud_rise: got=ud%b/ddone%0d required=ud1/ddone3", update_due, n_ddone - b_dd); end
    b_st = n_start;
    step_n(10);
    checks++; if ((n_start - b_st) !== 0 || d_grant !== 1'b0) begin failures++;
      $display("FAIL ud_stall: got=starts%0d/dgrant%b required=0/0", n_start - b_st, d_grant); end
    // Metadata read does not clear the counter.
    m_wr = 1'b0; m_sector = 32'h0000_0042; m_req = 1'b1;
    for (int i = 0; i < 20 && m_grant !== 1'b1; i++) step();
    m_req = 1'b0;
    for (int i = 0; i < 20 && m_done !== 1'b1; i++) step();
    step_n(3);
    checks++; if (update_due !== 1'b1 || d_grant !== 1'b0) begin failures++;
      $display("FAIL ud_read: got=ud%b/dgrant%b required=1/0", update_due, d_grant); end
    // Metadata write clears it; update_due follows one cycle after m_done.
    m_wr = 1'b1; m_sector = 32'h0000_0100; m_req = 1'b1;
    for (int i = 0; i < 20 && m_grant !== 1'b1; i++) step();
    m_req = 1'b0;
    checks++; if (h_sector !== 32'h0000_0100 || h_wr !== 1'b1) begin failures++;
      $display("FAIL ud_wr_cmd: got=%h/%b required=00000100/1", h_sector, h_wr); end
    for (int i = 0; i < 20 && m_done !== 1'b1; i++) step();
    checks++; if (m_done !== 1'b1 || update_due !== 1'b1) begin failures++;
      $display("FAIL ud_wdone: got=done%b/ud%b required=1/1", m_done, update_due); end
    step();
    checks++; if (update_due !== 1'b0) begin failures++;
      $display("FAIL ud_clear: got=%b required=0", update_due); end
    for (int i = 0; i < 20 && d_grant !== 1'b1; i++) step();
    checks++; if (d_grant !== 1'b1) begin failures++;
      $display("FAIL ud_resume: got=%b required=1", d_grant); end
    d_req = 1'b0;
    for (int i = 0; i < 20 && d_grant; i++) step();
    step_n(2);
  endtask

  task automatic test_done_at_expiry();
    int b_err;
    host_auto = 1'b0;
    b_err = n_merr + n_derr;
    m_wr = 1'b0; m_sector = 32'h0000_0777; m_req = 1'b1;
    for (int i = 0; i < 20 && h_start !== 1'b1; i++) step();
    m_req = 1'b0;
    step();                 // cycle 1
    tb_busy = 1'b1;
    step();                 // cycle 2
    tb_busy = 1'b0;
    step_n(97);             // cycle 99: expiry cycle
    tb_done = 1'b1;
    step();                 // cycle 100
    tb_done = 1'b0;
    checks++; if ({m_done, m_err, timeout_err} !== 3'b100) begin failures++;
      $display("FAIL exp_done: got=%b required=100", {m_done, m_err, timeout_err}); end
    step_n(2);
    checks++; if ((n_merr + n_derr - b_err) !== 0 || timeout_err !== 1'b0) begin failures++;
      $display("FAIL exp_noerr: got=err%0d/to%b required=0/0", n_merr + n_derr - b_err, timeout_err); end
  endtask

  task automatic test_timeout();
    int b_dd, b_de, err_cyc;
    b_dd = n_ddone; b_de = n_derr; err_cyc = -1;
    d_sector = 32'h0BAD_0000; d_req = 1'b1;
    for (int i = 0; i < 20 && h_start !== 1'b1; i++) step();
    d_req = 1'b0;
    checks++; if (h_sector !== 32'h0BAD_0000 || h_wr !== 1'b1 || d_grant !== 1'b1) begin failures++;
      $display("FAIL to_issue: got=%h/%b/%b required=0bad0000/1/1", h_sector, h_wr, d_grant); end
    for (int k = 1; k <= 110; k++) begin
      step();
      if (d_err === 1'b1 && err_cyc < 0) err_cyc = k;
    end
    checks++; if (err_cyc !== 100) begin failures++;
      $display("FAIL to_cycle: got=%0d required=100", err_cyc); end
    checks++; if (timeout_err !== 1'b1 || (n_ddone - b_dd) !== 0 || (n_derr - b_de) !== 1 || d_grant !== 1'b0) begin failures++;
      $display("FAIL to_flags: got=to%b/ddone%0d/derr%0d/gr%b required=1/0/1/0",
               timeout_err, n_ddone - b_dd, n_derr - b_de, d_grant); end
  endtask

  task automatic test_card_drop();
    int b_dd, b_st, b_md;
    b_dd = n_ddone;
    d_sector = 32'h0000_3000; d_req = 1'b1;
    for (int i = 0; i < 20 && h_start !== 1'b1; i++) step();
    d_req = 1'b0;
    step();
    tb_busy = 1'b1;
    step();                 // WAIT_DONE
    tb_busy = 1'b0;
    step();
    card_ready = 1'b0;
    step();
    checks++; if ({d_err, d_grant, timeout_err} !== 3'b101) begin failures++;
      $display("FAIL cd_err: got=%b required=101", {d_err, d_grant, timeout_err}); end
    step();
    checks++; if (d_err !== 1'b0 || (n_ddone - b_dd) !== 0) begin failures++;
      $display("FAIL cd_pulse: got=err%b/ddone%0d required=0/0", d_err, n_ddone - b_dd); end
    // No grant without a ready card; stray host completion is ignored.
    b_st = n_start; b_md = n_mdone + n_ddone;
    m_wr = 1'b0; m_sector = 32'h0000_0009; m_req = 1'b1;
    step_n(6);
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    step_n(2);
    checks++; if ((n_start - b_st) !== 0 || m_grant !== 1'b0 || (n_mdone + n_ddone - b_md) !== 0) begin failures++;
      $display("FAIL cd_idle: got=starts%0d/gr%b/done%0d required=0/0/0",
               n_start - b_st, m_grant, n_mdone + n_ddone - b_md); end
    host_auto = 1'b1;
    card_ready = 1'b1;
    step();
    checks++; if (m_grant !== 1'b1 || h_start !== 1'b1) begin failures++;
      $display("FAIL cd_resume: got=gr%b/start%b required=1/1", m_grant, h_start); end
    m_req = 1'b0;
    for (int i = 0; i < 20 && m_grant; i++) step();
    step_n(2);
    host_auto = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b_p, b_st;
    m_wr = 1'b1; m_sector = 32'h0000_0055; m_req = 1'b1;
    for (int i = 0; i < 20 && h_start !== 1'b1; i++) step();
    m_req = 1'b0;
    step();
    tb_busy = 1'b1;
    step();
    tb_busy = 1'b0;
    b_p = n_mdone + n_ddone + n_merr + n_derr;
    b_st = n_start;
    rstn = 1'b0;
    step_n(2);
    checks++; if ({m_grant, timeout_err, sel, h_wr} !== 4'b0 || h_sector !== 32'h0) begin failures++;
      $display("FAIL rm_state: got=%b/%h required=0000/0", {m_grant, timeout_err, sel, h_wr}, h_sector); end
    rstn = 1'b1;
    step_n(4);
    checks++; if ((n_mdone + n_ddone + n_merr + n_derr - b_p) !== 0 || (n_start - b_st) !== 0) begin failures++;
      $display("FAIL rm_silent: got=pulses%0d/starts%0d required=0/0",
               n_mdone + n_ddone + n_merr + n_derr - b_p, n_start - b_st); end
  endtask

  initial begin
    test_reset();
    test_meta_read();
    test_alternate();
    test_update_due();
    test_done_at_expiry();
    test_timeout();
    test_card_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter UPDATE_EVERY, default 16; data sectors completed before a filesystem update is forced (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576; max clk cycles per host transaction (24-bit counter).
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port card_ready  in  1  SD host initialised (card state reached transfer-ready).
REQ-006 SHALL have ports m_req/m_wr/m_sector  in  1/1/32  metadata requester: request, 1=write 0=read, sector address.
REQ-007 SHALL have ports m_grant/m_done/m_err  out  1/1/1  metadata grant level, done pulse, error pulse.
REQ-008 SHALL have ports d_req/d_sector  in  1/32  data-stream requester (always write).
REQ-009 SHALL have ports d_grant/d_done/d_err  out  1/1/1  data grant level, done pulse, error pulse.
REQ-010 SHALL have ports h_start/h_wr/h_sector  out  1/1/32  host command: start pulse, direction, sector.
REQ-011 SHALL have ports h_busy/h_done  in  1/1  host busy level, completion pulse.
REQ-012 SHALL have port sel  out  1  bus owner for byte/SD-line muxing: 0=metadata, 1=data; holds last owner when idle.
REQ-013 SHALL have ports update_due/timeout_err  out  1/1  forced-update flag; sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH.
REQ-015 IDLE: no grant while card_ready=0; otherwise arbitrate among sampled requests, latch owner, direction, sector; go ISSUE next cycle.
REQ-016 Arbitration: update_due=1 -> only m_req eligible (data stalls even if m_req=0); else round-robin, loser of last contention first; single requester wins immediately.
REQ-017 ISSUE (one cycle): h_start=1, h_sector/h_wr driven from latched values, owner grant rises; h_wr forced 1 for data owner.
REQ-018 Grant, sel, h_sector, h_wr SHALL stay stable from ISSUE until FINISH inclusive.
REQ-019 WAIT_BUSY: advance to WAIT_DONE on h_busy=1; h_done=1 here also accepted (goes FINISH).
REQ-020 WAIT_DONE: on h_done=1 go FINISH.
REQ-021 FINISH (one cycle): owner done pulse=1, grant drops next cycle, return IDLE; request-to-grant latency 2 cycles, done-to-next-grant minimum 2 cycles.
REQ-022 Requester deassertion of req after grant SHALL be ignored; transaction completes.
REQ-023 Data counter (8 bits): +1 on each d_done; cleared on m_done with latched m_wr=1; saturates at 255; m_done on read does not clear.
REQ-024 update_due SHALL equal (data counter >= UPDATE_EVERY), registered.
REQ-025 Watchdog cleared in ISSUE, increments in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES -> owner err pulse (no done), timeout_err set, IDLE.
REQ-026 h_done and timeout in same cycle: done wins, no error.
REQ-027 card_ready falling during ISSUE/WAIT_*: owner err pulse next cycle, return IDLE, timeout_err unaffected.
REQ-028 h_done while IDLE SHALL be ignored.
REQ-029 Errored data transaction SHALL NOT increment data counter.

Reset
REQ-030 On rstn=0: state IDLE, all grants/done/err/h_start/h_wr=0, h_sector=0, sel=0, counter=0, update_due=0, timeout_err=0, round-robin pointer=metadata-first.
REQ-031 Reset mid-transaction SHALL abort silently with no done/err pulse.

Structure
REQ-032 Shared package sd_sched_pkg SHALL hold state encodings, owner codes (OWN_META=0, OWN_DATA=1) and default parameter constants.
REQ-033 Watchdog SHALL be sub-module sd_watchdog_counter (clear, enable, limit, expired).

Verification
REQ-034 m_req=1 only, m_wr=0, sector 0x0000_0000, host busy 3 cycles -> h_start pulse cycle 2, h_wr=0, m_done once, counter unchanged.
REQ-035 m_req and d_req both asserted continuously -> grants alternate M,D,M,D; sel tracks owner.
REQ-036 UPDATE_EVERY=4, 4 data writes -> update_due=1, d_req stalls; m_req write -> m_done, counter=0, update_due=0 next cycle.
REQ-037 TIMEOUT_CYCLES=100, h_busy never asserted -> d_err pulse at cycle 100 after ISSUE, timeout_err=1, no d_done.
REQ-038 h_done coincident with watchdog expiry -> done pulse, timeout_err stays 0; card_ready drop in WAIT_DONE -> err pulse, IDLE.
